acc_readout_serializer: RTL and testbench



---
 rtl/acc_readout_pkg.sv | 19 +
 rtl/acc_readout_serializer_narrow.sv | 41 ++++
 rtl/acc_readout_serializer.sv | 117 +++++++++++
 tb/tb_acc_readout_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_readout_pkg.sv
// rtl/acc_readout_pkg.sv - shared types, default widths and index-width helper for the readout serializer
package acc_readout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int DEF_NUM_ELEM  = 16;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_OUT_WIDTH = 16;

    // Index is at least one bit wide so a single-element bank still has a legal port.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/acc_readout_serializer_narrow.sv
// rtl/acc_readout_serializer_narrow.sv - ACC_W to OUT_W converter; signed saturation when ACC_READOUT_SAT_EN is defined
module acc_sat_narrow #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic [ACC_W-1:0] din,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

`ifdef ACC_READOUT_SAT_EN
    logic [ACC_W-OUT_W:0] hi_bits;
    logic [OUT_W-1:0]     min_neg;
    logic                 ovf;

    // The value fits when every bit from the output sign bit upward agrees.
    assign hi_bits = din[ACC_W-1:OUT_W-1];
    assign ovf     = !((&hi_bits) || !(|hi_bits));

    always_comb begin
        min_neg          = '0;
        min_neg[OUT_W-1] = 1'b1;
        if (!ovf) begin
            dout = din[OUT_W-1:0];
        end else if (din[ACC_W-1]) begin
            dout = min_neg;
        end else begin
            dout = ~min_neg;
        end
    end

    assign sat = ovf;
`else
    logic unused_hi;

    assign dout      = din[OUT_W-1:0];
    assign sat       = 1'b0;
    assign unused_hi = ^din;
`endif

endmodule

// File: rtl/acc_readout_serializer.sv
// rtl/acc_readout_serializer.sv - snapshot accumulator sums and stream them out; ACC_READOUT_SAT_EN adds saturation and sat_flag
module acc_readout_serializer
    import acc_readout_pkg::*;
#(
    parameter int NUM_ELEM = DEF_NUM_ELEM,
    parameter int ACC_W    = DEF_ACC_WIDTH,
    parameter int OUT_W    = DEF_OUT_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [NUM_ELEM-1:0][ACC_W-1:0]     sum_in,
    output logic                               acc_clear,
    output logic                               busy,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [OUT_W-1:0]                   m_data,
    output logic [idx_w(NUM_ELEM)-1:0]         m_index,
    output logic                               m_last,
    output logic                               done
`ifdef ACC_READOUT_SAT_EN
    ,
    output logic                               sat_flag
`endif
);

    localparam int IDX_W = idx_w(NUM_ELEM);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NUM_ELEM-1:0][ACC_W-1:0] snap_q, snap_d;
    logic                         clr_q, clr_d;

    logic                         last_beat;
    logic                         streaming;
    logic [ACC_W-1:0]             cur_elem;
    logic [OUT_W-1:0]             narrow_data;
    logic                         narrow_sat;

    assign cur_elem  = snap_q[idx_q];
    assign last_beat = (idx_q == IDX_W'(NUM_ELEM - 1));
    assign streaming = (state_q == STREAM);

    acc_sat_narrow #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_narrow (
        .din  (cur_elem),
        .dout (narrow_data),
        .sat  (narrow_sat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = sum_in;
                    idx_d   = '0;
                    clr_d   = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (m_ready) begin
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            clr_q   <= clr_d;
        end
    end

    // Beat fields are forced to zero outside STREAM so idle/done cycles never show stale data.
    assign acc_clear = clr_q;
    assign busy      = (state_q != IDLE);
    assign m_valid   = streaming;
    assign done      = (state_q == DONE);
    assign m_data    = streaming ? narrow_data : '0;
    assign m_index   = streaming ? idx_q : '0;
    assign m_last    = streaming && last_beat;

`ifdef ACC_READOUT_SAT_EN
    assign sat_flag  = streaming && narrow_sat;
`else
    logic unused_sat;
    assign unused_sat = narrow_sat;
`endif

endmodule

// File: tb/tb_acc_readout_serializer.sv
// tb/tb_acc_readout_serializer.sv - self-checking bench for acc_readout_serializer (ACC_READOUT_SAT_EN aware)
module tb_acc_readout_serializer;

    localparam int N     = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic [N-1:0][ACC_W-1:0]  sum_in;
    logic                     acc_clear;
    logic                     busy;
    logic                     m_valid;
    logic                     m_ready;
    logic [OUT_W-1:0]         m_data;
    logic [1:0]               m_index;
    logic                     m_last;
    logic                     done;
`ifdef ACC_READOUT_SAT_EN
    logic                     sat_flag;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    acc_readout_serializer #(
        .NUM_ELEM (N),
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sum_in    (sum_in),
        .acc_clear (acc_clear),
        .busy      (busy),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_index   (m_index),
        .m_last    (m_last),
        .done      (done)
`ifdef ACC_READOUT_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference narrowing: {saturated, value} computed with plain signed arithmetic.
    function automatic logic [OUT_W:0] ref_narrow(input logic [ACC_W-1:0] v);
        longint s;
        longint maxp;
        longint minn;
        logic [OUT_W-1:0] r;
        s    = longint'($signed(v));
        maxp = (longint'(1) << (OUT_W - 1)) - 1;
        minn = -(longint'(1) << (OUT_W - 1));
        r    = v[OUT_W-1:0];
`ifdef ACC_READOUT_SAT_EN
        if (s > maxp) return {1'b1, OUT_W'(maxp)};
        if (s < minn) return {1'b1, OUT_W'(minn)};
`endif
        return {1'b0, r};
    endfunction

    // Model: expected snapshot plus a position pointer into it.
    logic [OUT_W:0] mdl_exp [N];
    int             mdl_pos;
    logic           mdl_stream, mdl_done, mdl_clear;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_pos    <= 0;
            mdl_stream <= 1'b0;
            mdl_done   <= 1'b0;
            mdl_clear  <= 1'b0;
            for (int i = 0; i < N; i++) mdl_exp[i] <= '0;
        end else begin
            mdl_clear <= 1'b0;
            if (mdl_done) begin
                mdl_done <= 1'b0;
            end else if (mdl_stream) begin
                if (m_ready) begin
                    if (mdl_pos == N - 1) begin
                        mdl_stream <= 1'b0;
                        mdl_done   <= 1'b1;
                        mdl_pos    <= 0;
                    end else begin
                        mdl_pos <= mdl_pos + 1;
                    end
                end
            end else if (start) begin
                for (int i = 0; i < N; i++) mdl_exp[i] <= ref_narrow(sum_in[i]);
                mdl_pos    <= 0;
                mdl_stream <= 1'b1;
                mdl_clear  <= 1'b1;
            end
        end
    end

    logic [OUT_W-1:0] prev_data;
    logic [1:0]       prev_index;
    logic             prev_last;
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] accepted [$];

    always @(negedge clk) begin
        chk("busy", busy, mdl_stream || mdl_done);
        chk("acc_clear", acc_clear, mdl_clear);
        chk("m_valid", m_valid, mdl_stream);
        chk("done", done, mdl_done);
        if (mdl_stream) begin
            chk("m_data", m_data, mdl_exp[mdl_pos][OUT_W-1:0]);
            chk("m_index", m_index, mdl_pos);
            chk("m_last", m_last, mdl_pos == N - 1);
`ifdef ACC_READOUT_SAT_EN
            chk("sat_flag", sat_flag, mdl_exp[mdl_pos][OUT_W]);
`endif
        end
        if (acc_clear) chk("clear_on_first_beat", m_valid && (m_index == 2'd0), 1);
        if (prev_stall && rst_n) begin
            chk("stall_data", m_data, prev_data);
            chk("stall_index", m_index, prev_index);
            chk("stall_last", m_last, prev_last);
        end
        if (m_valid && m_ready) accepted.push_back(m_data);
        prev_stall = rst_n && m_valid && !m_ready;
        prev_data  = m_data;
        prev_index = m_index;
        prev_last  = m_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_index"}, m_index, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_clear"}, acc_clear, 0);
`ifdef ACC_READOUT_SAT_EN
        chk({tag, "_sat"}, sat_flag, 0);
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        sum_in  = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_valid", m_valid, 0);
        end

        // Basic stream with ready held high.
        sum_in  = {32'd40, 32'd30, 32'd20, 32'd10};
        m_ready = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("basic_clear", acc_clear, k == 0);
            chk("basic_valid", m_valid, 1);
            chk("basic_data", m_data, 10 * (k + 1));
            chk("basic_index", m_index, k);
            chk("basic_last", m_last, k == N - 1);
            tick();
        end
        chk("basic_done", done, 1);
        chk("basic_done_valid", m_valid, 0);
        tick();
        chk("basic_idle", busy, 0);
        chk("basic_done_pulse", done, 0);

        // Backpressure 1,0,0 with stray start pulses mid-stream.
        accepted.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && busy; c++) begin
            m_ready = (c % 3 == 0);
            start   = (c == 2 || c == 5);
            tick();
        end
        start   = 1'b0;
        m_ready = 1'b1;
        wait_idle(10);
        chk("bp_count", accepted.size(), 4);
        for (int k = 0; k < 4 && k < accepted.size(); k++)
            chk("bp_beat", accepted[k], 10 * (k + 1));

        // Narrowing corner values.
        sum_in = {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h0001_8000};
        start  = 1'b1;
        tick();
        start = 1'b0;
`ifdef ACC_READOUT_SAT_EN
        chk("narrow_pos_ovf", m_data, 16'h7FFF);
        chk("narrow_pos_sat", sat_flag, 1);
`else
        chk("narrow_pos_wrap", m_data, 16'h8000);
`endif
        tick();
        chk("narrow_neg_small", m_data, 16'hFFFE);
`ifdef ACC_READOUT_SAT_EN
        chk("narrow_neg_small_sat", sat_flag, 0);
`endif
        tick();
        tick();
`ifdef ACC_READOUT_SAT_EN
        chk("narrow_neg_ovf", m_data, 16'h8000);
`else
        chk("narrow_neg_wrap", m_data, 16'h0000);
`endif
        wait_idle(10);

        // Reset mid-stream at index 2, then a fresh restart.
        sum_in = {32'd4, 32'd3, 32'd2, 32'd1};
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_index", m_index, 2);
        chk("mid_data", m_data, 3);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rst_n  = 1'b1;
        sum_in = {32'd8, 32'd7, 32'd6, 32'd5};
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_clear", acc_clear, 1);
        chk("restart_index", m_index, 0);
        chk("restart_data", m_data, 5);
        wait_idle(20);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
